// File: rtl/stack_call_ctrl.sv
// Arbiter/sequencer sharing the LEG hardware Stack between CALL/RET and PUSH/POP traffic.
// Runs one operation at a time (IDLE -> ISSUE -> DONE), tracks depth and blocks over/underflow.
module stack_call_ctrl #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 15,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CALL,
   input  logic              RET,
   input  logic              PUSH_REQ,
   input  logic              POP_REQ,
   input  logic [DATA_W-1:0] PC_NEXT,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic [DATA_W-1:0] STK_TOP,
   input  logic              CLR_ERR,
   output logic              STK_PUSH,
   output logic              STK_POP,
   output logic [DATA_W-1:0] STK_VALUE,
   output logic              ACK_CALL,
   output logic              ACK_RET,
   output logic              ACK_PUSH,
   output logic              ACK_POP,
   output logic [DATA_W-1:0] RET_ADDR,
   output logic              RET_VALID,
   output logic [DATA_W-1:0] POP_DATA,
   output logic              POP_VALID,
   output logic [CNT_W-1:0]  COUNT,
   output logic              FULL,
   output logic              EMPTY,
   output logic              OVERFLOW,
   output logic              UNDERFLOW,
   output logic              BUSY
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [1:0] OP_RET  = 2'd0;
   localparam logic [1:0] OP_CALL = 2'd1;
   localparam logic [1:0] OP_POP  = 2'd2;
   localparam logic [1:0] OP_PUSH = 2'd3;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [1:0]        state;
   logic [1:0]        op;
   logic [DATA_W-1:0] op_val;
   logic [CNT_W-1:0]  count;
   logic              ovf_q;
   logic              udf_q;
   logic [DATA_W-1:0] ret_addr_q;
   logic [DATA_W-1:0] pop_data_q;

   logic              req_any;
   logic [1:0]        win_op;
   logic [DATA_W-1:0] win_val;
   logic              in_issue;
   logic              in_done;
   logic              op_is_push;
   logic              is_full;
   logic              is_empty;
   logic              do_push;
   logic              do_pop;
   logic              set_ovf;
   logic              set_udf;
   logic [DATA_W-1:0] pop_val;

   // Depth update that can never wrap past 0 or DEPTH.
   function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
      logic [CNT_W-1:0] r;
      r = cnt;
      if (inc && cnt != DEPTH_C)
         r = cnt + CNT_W'(1);
      else if (dec && cnt != '0)
         r = cnt - CNT_W'(1);
      return r;
   endfunction

   // Sticky flag: a set in the same cycle as a clear takes precedence.
   function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
      return set | (cur & ~clr);
   endfunction

   // Fixed priority RET > CALL > POP_REQ > PUSH_REQ; losers simply stay asserted.
   always_comb begin
      req_any = RET | CALL | POP_REQ | PUSH_REQ;
      win_op  = OP_PUSH;
      win_val = DATA_IN;
      if (RET) begin
         win_op = OP_RET;
      end else if (CALL) begin
         win_op  = OP_CALL;
         win_val = PC_NEXT;
      end else if (POP_REQ) begin
         win_op = OP_POP;
      end
   end

   assign in_issue   = (state == ST_ISSUE);
   assign in_done    = (state == ST_DONE);
   assign op_is_push = (op == OP_CALL) || (op == OP_PUSH);
   assign is_full    = (count == DEPTH_C);
   assign is_empty   = (count == '0);

   assign do_push = in_issue &  op_is_push & ~is_full;
   assign do_pop  = in_issue & ~op_is_push & ~is_empty;
   assign set_ovf = in_issue &  op_is_push &  is_full;
   assign set_udf = in_issue & ~op_is_push &  is_empty;
   assign pop_val = do_pop ? STK_TOP : '0;

   // Control state: FSM, depth, sticky errors and the registered pop results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         op         <= OP_RET;
         count      <= '0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         ret_addr_q <= '0;
         pop_data_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_any) begin
                  op    <= win_op;
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: state <= ST_DONE;
            default:  state <= ST_IDLE;
         endcase

         count <= sat_count(count, do_push, do_pop);
         ovf_q <= sticky_next(ovf_q, set_ovf, CLR_ERR);
         udf_q <= sticky_next(udf_q, set_udf, CLR_ERR);

         if (in_issue && op == OP_RET)
            ret_addr_q <= pop_val;
         if (in_issue && op == OP_POP)
            pop_data_q <= pop_val;
      end
   end

   // Operand latched with the winner; only observed on STK_VALUE during ISSUE.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && req_any)
         op_val <= win_val;
   end

   assign STK_PUSH  = do_push;
   assign STK_POP   = do_pop;
   assign STK_VALUE = do_push ? op_val : '0;

   assign ACK_RET  = in_issue && (op == OP_RET);
   assign ACK_CALL = in_issue && (op == OP_CALL);
   assign ACK_POP  = in_issue && (op == OP_POP);
   assign ACK_PUSH = in_issue && (op == OP_PUSH);

   assign RET_VALID = in_done && (op == OP_RET);
   assign POP_VALID = in_done && (op == OP_POP);
   assign RET_ADDR  = ret_addr_q;
   assign POP_DATA  = pop_data_q;

   assign COUNT     = count;
   assign FULL      = is_full;
   assign EMPTY     = is_empty;
   assign OVERFLOW  = ovf_q;
   assign UNDERFLOW = udf_q;
   assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_stack_call_ctrl.sv
// Directed bench for stack_call_ctrl: vector table of single operations plus
// hand-written priority, overflow/clear and mid-operation reset sequences.
module tb_stack_call_ctrl;

   localparam int K_RET  = 0;
   localparam int K_CALL = 1;
   localparam int K_POP  = 2;
   localparam int K_PUSH = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       CALL, RET, PUSH_REQ, POP_REQ;
   logic [7:0] PC_NEXT, DATA_IN, STK_TOP;
   logic       CLR_ERR;
   logic       STK_PUSH, STK_POP;
   logic [7:0] STK_VALUE;
   logic       ACK_CALL, ACK_RET, ACK_PUSH, ACK_POP;
   logic [7:0] RET_ADDR;
   logic       RET_VALID;
   logic [7:0] POP_DATA;
   logic       POP_VALID;
   logic [3:0] COUNT;
   logic       FULL, EMPTY, OVERFLOW, UNDERFLOW, BUSY;

   int n_checks = 0;
   int n_pass   = 0;

   stack_call_ctrl #(.DATA_W(8), .DEPTH(15), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .CALL(CALL), .RET(RET), .PUSH_REQ(PUSH_REQ), .POP_REQ(POP_REQ),
      .PC_NEXT(PC_NEXT), .DATA_IN(DATA_IN), .STK_TOP(STK_TOP), .CLR_ERR(CLR_ERR),
      .STK_PUSH(STK_PUSH), .STK_POP(STK_POP), .STK_VALUE(STK_VALUE),
      .ACK_CALL(ACK_CALL), .ACK_RET(ACK_RET), .ACK_PUSH(ACK_PUSH), .ACK_POP(ACK_POP),
      .RET_ADDR(RET_ADDR), .RET_VALID(RET_VALID), .POP_DATA(POP_DATA), .POP_VALID(POP_VALID),
      .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .BUSY(BUSY)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         kind;
      logic [7:0] val;
      logic [7:0] top;
      logic       e_push;
      logic       e_pop;
      logic [7:0] e_data;
      logic [3:0] e_count;
      logic       e_ovf;
      logic       e_udf;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic set_req(input int kind, input logic v);
      case (kind)
         K_RET:   RET      = v;
         K_CALL:  CALL     = v;
         K_POP:   POP_REQ  = v;
         default: PUSH_REQ = v;
      endcase
   endtask

   function automatic logic ack_of(input int kind);
      case (kind)
         K_RET:   return ACK_RET;
         K_CALL:  return ACK_CALL;
         K_POP:   return ACK_POP;
         default: return ACK_PUSH;
      endcase
   endfunction

   // Raises one request at an idle DUT, checks the ISSUE and DONE cycles, leaves DUT idle.
   task automatic run_op(input string name, input int kind, input logic [7:0] val,
                         input logic [7:0] top, input logic e_push, input logic e_pop,
                         input logic [7:0] e_data, input logic [3:0] e_count,
                         input logic e_ovf, input logic e_udf);
      logic got;
      logic is_pop;
      got    = 1'b0;
      is_pop = (kind == K_RET) || (kind == K_POP);
      PC_NEXT = (kind == K_CALL) ? val : 8'h00;
      DATA_IN = (kind == K_PUSH) ? val : 8'h00;
      STK_TOP = top;
      set_req(kind, 1'b1);
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         got = ack_of(kind);
      end
      check({name, " ack"}, 32'(got), 32'd1);
      if (got) begin
         check({name, " stk_push"}, 32'(STK_PUSH), 32'(e_push));
         check({name, " stk_pop"}, 32'(STK_POP), 32'(e_pop));
         if (e_push)
            check({name, " stk_value"}, 32'(STK_VALUE), 32'(val));
      end
      @(posedge clk); #1;
      set_req(kind, 1'b0);
      @(negedge clk);
      check({name, " ret_valid"}, 32'(RET_VALID), 32'(kind == K_RET));
      check({name, " pop_valid"}, 32'(POP_VALID), 32'(kind == K_POP));
      if (is_pop)
         check({name, " data"}, 32'((kind == K_RET) ? RET_ADDR : POP_DATA), 32'(e_data));
      check({name, " count"}, 32'(COUNT), 32'(e_count));
      check({name, " full"}, 32'(FULL), 32'(e_count == 4'd15));
      check({name, " empty"}, 32'(EMPTY), 32'(e_count == 4'd0));
      check({name, " ovf"}, 32'(OVERFLOW), 32'(e_ovf));
      check({name, " udf"}, 32'(UNDERFLOW), 32'(e_udf));
      @(posedge clk); #1;
   endtask

   task automatic pulse_clr;
      CLR_ERR = 1'b1;
      @(posedge clk); #1;
      CLR_ERR = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int k_ret, k_call, k_pop, k_push;
      logic [7:0] call_val, push_val;

      vecs[0] = '{K_CALL, 8'h42, 8'h00, 1'b1, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0};
      vecs[1] = '{K_RET,  8'h00, 8'h42, 1'b0, 1'b1, 8'h42, 4'd0, 1'b0, 1'b0};
      vecs[2] = '{K_PUSH, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0};
      vecs[3] = '{K_POP,  8'h00, 8'hA5, 1'b0, 1'b1, 8'hA5, 4'd0, 1'b0, 1'b0};
      vecs[4] = '{K_POP,  8'h00, 8'h5C, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1};
      vecs[5] = '{K_PUSH, 8'h11, 8'h00, 1'b1, 1'b0, 8'h00, 4'd1, 1'b0, 1'b1};
      vecs[6] = '{K_CALL, 8'h22, 8'h00, 1'b1, 1'b0, 8'h00, 4'd2, 1'b0, 1'b1};

      rst = 1'b1;
      CALL = 0; RET = 0; PUSH_REQ = 0; POP_REQ = 0; CLR_ERR = 0;
      PC_NEXT = 0; DATA_IN = 0; STK_TOP = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst count", 32'(COUNT), 32'd0);
      check("rst empty", 32'(EMPTY), 32'd1);
      check("rst full", 32'(FULL), 32'd0);
      check("rst busy", 32'(BUSY), 32'd0);
      check("rst strobes", 32'({STK_PUSH, STK_POP}), 32'd0);
      check("rst acks", 32'({ACK_CALL, ACK_RET, ACK_PUSH, ACK_POP}), 32'd0);
      check("rst valids", 32'({RET_VALID, POP_VALID}), 32'd0);
      check("rst flags", 32'({OVERFLOW, UNDERFLOW}), 32'd0);
      check("rst values", 32'({STK_VALUE, RET_ADDR, POP_DATA}), 32'd0);
      @(posedge clk); #1;

      for (int v = 0; v < 7; v++)
         run_op($sformatf("vec%0d", v), vecs[v].kind, vecs[v].val, vecs[v].top,
                vecs[v].e_push, vecs[v].e_pop, vecs[v].e_data, vecs[v].e_count,
                vecs[v].e_ovf, vecs[v].e_udf);

      pulse_clr();
      check("clr udf", 32'(UNDERFLOW), 32'd0);
      check("clr keeps count", 32'(COUNT), 32'd2);
      @(posedge clk); #1;

      // All four requests together at COUNT=2; each is dropped the cycle after its ACK.
      k_ret = -1; k_call = -1; k_pop = -1; k_push = -1;
      call_val = 8'h00; push_val = 8'h00;
      PC_NEXT = 8'h77; DATA_IN = 8'h88; STK_TOP = 8'h3C;
      RET = 1; CALL = 1; POP_REQ = 1; PUSH_REQ = 1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (ACK_RET)  k_ret = k;
         if (ACK_CALL) begin k_call = k; call_val = STK_VALUE; end
         if (ACK_POP)  k_pop = k;
         if (ACK_PUSH) begin k_push = k; push_val = STK_VALUE; end
         @(posedge clk); #1;
         if (ACK_RET === 1'b0 && k_ret >= 0)   RET = 0;
         if (ACK_CALL === 1'b0 && k_call >= 0) CALL = 0;
         if (ACK_POP === 1'b0 && k_pop >= 0)   POP_REQ = 0;
         if (ACK_PUSH === 1'b0 && k_push >= 0) PUSH_REQ = 0;
      end
      check("prio ret cycle", 32'(k_ret), 32'd1);
      check("prio call cycle", 32'(k_call), 32'd4);
      check("prio pop cycle", 32'(k_pop), 32'd7);
      check("prio push cycle", 32'(k_push), 32'd10);
      check("prio call value", 32'(call_val), 32'h77);
      check("prio push value", 32'(push_val), 32'h88);
      check("prio ret addr", 32'(RET_ADDR), 32'h3C);
      check("prio pop data", 32'(POP_DATA), 32'h3C);
      check("prio count", 32'(COUNT), 32'd2);
      check("prio busy", 32'(BUSY), 32'd0);

      run_op("drain1", K_POP, 8'h00, 8'h88, 1'b0, 1'b1, 8'h88, 4'd1, 1'b0, 1'b0);
      run_op("drain0", K_POP, 8'h00, 8'h77, 1'b0, 1'b1, 8'h77, 4'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 15; i++)
         run_op($sformatf("fill%0d", i), K_PUSH, 8'(i), 8'h00, 1'b1, 1'b0, 8'h00,
                4'(i), 1'b0, 1'b0);
      run_op("push full", K_PUSH, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 4'd15, 1'b1, 1'b0);

      pulse_clr();
      check("clr ovf", 32'(OVERFLOW), 32'd0);
      check("clr full", 32'(FULL), 32'd1);
      @(posedge clk); #1;

      run_op("pop15", K_POP, 8'h00, 8'h0F, 1'b0, 1'b1, 8'h0F, 4'd14, 1'b0, 1'b0);

      // Reset lands in the middle of a push's ISSUE cycle.
      DATA_IN = 8'h5A;
      PUSH_REQ = 1;
      @(posedge clk); #1;
      check("mid push strobe", 32'(STK_PUSH), 32'd1);
      check("mid push ack", 32'(ACK_PUSH), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("mid rst strobe", 32'(STK_PUSH), 32'd0);
      check("mid rst count", 32'(COUNT), 32'd0);
      check("mid rst busy", 32'(BUSY), 32'd0);
      check("mid rst ack", 32'(ACK_PUSH), 32'd0);
      PUSH_REQ = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post rst strobe", 32'(STK_PUSH), 32'd0);
      check("post rst count", 32'(COUNT), 32'd0);
      check("post rst empty", 32'(EMPTY), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
